// File: rtl/multicycle_decode_pkg.sv
// Shared types and constants for the multicycle control unit: FSM state
// encoding, ALU/FPU operation codes and instruction Op-field classes.
package multicycle_decode_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      MULEX    = 4'd10,
      MULWB_HI = 4'd11,
      FPUEX    = 4'd12,
      FPUWB    = 4'd13
   } state_e;

   // ALU operation codes (3-bit core encoding, zero-extended at the port)
   localparam logic [2:0] ALU_ADD     = 3'b000;
   localparam logic [2:0] ALU_SUB     = 3'b001;
   localparam logic [2:0] ALU_AND     = 3'b010;
   localparam logic [2:0] ALU_ORR     = 3'b011;
   localparam logic [2:0] ALU_MUL     = 3'b100;
   localparam logic [2:0] ALU_UMULL   = 3'b101;
   localparam logic [2:0] ALU_SMULL   = 3'b110;
   localparam logic [2:0] ALU_ILLEGAL = 3'b111;

   // FPU operation codes, taken straight from Funct[2:1]
   localparam logic [1:0] FPU_ADD = 2'b00;
   localparam logic [1:0] FPU_SUB = 2'b01;
   localparam logic [1:0] FPU_MUL = 2'b10;
   localparam logic [1:0] FPU_DIV = 2'b11;

   // Instruction class in instr[27:26]
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_FPU = 2'b11;

   // Multiply instructions are tagged by instr[7:4] = 1001
   localparam logic [3:0] MULOP_MUL = 4'b1001;

endpackage

// File: rtl/multicycle_decode_fn.sv
// Combinational Funct/MulOp decode: ALU and FPU operation selection,
// flag-write enables and legality of the encoding.
module multicycle_decode_fn
   import multicycle_decode_pkg::*;
#(
   parameter int ALU_CTRL_W = 3,
   parameter int FPU_CTRL_W = 2
) (
   input  logic [5:0]            funct_i,
   input  logic [3:0]            mul_op_i,
   output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
   output logic [FPU_CTRL_W-1:0] fpu_ctrl_o,
   output logic [1:0]            flag_w_o,
   output logic                  alu_legal_o,
   output logic                  fpu_legal_o,
   output logic                  is_mul_o,
   output logic                  is_long_mul_o
);

   logic [2:0] alu_op_s;
   logic       is_mul_s;

   // A multiply only exists in the register form; the immediate form reuses instr[7:4]
   assign is_mul_s = (mul_op_i == MULOP_MUL) && !funct_i[5];

   // Pick the ALU operation from the multiply table or the data-processing table
   always_comb begin
      alu_op_s = ALU_ILLEGAL;
      if (is_mul_s) begin
         case (funct_i[3:1])
            3'b000:  alu_op_s = ALU_MUL;
            3'b100:  alu_op_s = ALU_UMULL;
            3'b110:  alu_op_s = ALU_SMULL;
            default: alu_op_s = ALU_ILLEGAL;
         endcase
      end else begin
         case (funct_i[4:1])
            4'b0100: alu_op_s = ALU_ADD;
            4'b0010: alu_op_s = ALU_SUB;
            4'b0000: alu_op_s = ALU_AND;
            4'b1100: alu_op_s = ALU_ORR;
            default: alu_op_s = ALU_ILLEGAL;
         endcase
      end
   end

   assign alu_legal_o   = (alu_op_s != ALU_ILLEGAL);
   assign alu_ctrl_o    = alu_legal_o ? ALU_CTRL_W'(alu_op_s) : {ALU_CTRL_W{1'b1}};
   assign is_mul_o      = is_mul_s;
   assign is_long_mul_o = is_mul_s && ((alu_op_s == ALU_UMULL) || (alu_op_s == ALU_SMULL));

   // C/V flags only make sense for arithmetic; an unsupported encoding writes nothing
   assign flag_w_o = alu_legal_o
                   ? {funct_i[0], funct_i[0] & ((alu_op_s == ALU_ADD) || (alu_op_s == ALU_SUB))}
                   : 2'b00;

   assign fpu_legal_o = (funct_i[4:3] == 2'b00);
   assign fpu_ctrl_o  = FPU_CTRL_W'(funct_i[2:1]);

endmodule

// File: rtl/multicycle_decode.sv
// Multicycle Moore control unit: sequences fetch, decode, memory, ALU,
// iterative multiply and FPU handshake across cycles.
module multicycle_decode
   import multicycle_decode_pkg::*;
#(
   parameter int ALU_CTRL_W = 3,
   parameter int FPU_CTRL_W = 2,
   parameter int MUL_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            Op,
   input  logic [5:0]            Funct,
   input  logic [3:0]            Rd,
   input  logic [3:0]            MulOp,
   input  logic                  fpu_done,
   output logic                  IRWrite,
   output logic                  NextPC,
   output logic                  Branch,
   output logic                  RegW,
   output logic                  MemW,
   output logic                  AdrSrc,
   output logic                  ALUSrcA,
   output logic                  mul_hi,
   output logic                  fpu_start,
   output logic [1:0]            ResultSrc,
   output logic [1:0]            ALUSrcB,
   output logic [1:0]            ImmSrc,
   output logic [1:0]            RegSrc,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic [FPU_CTRL_W-1:0] FPUControl,
   output logic [1:0]            FlagW,
   output logic [1:0]            FPUFlagW
);

   localparam int              CNT_W      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MUL_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fpu_first_q, fpu_first_d;

   logic [ALU_CTRL_W-1:0] dec_alu_ctrl_s;
   logic [FPU_CTRL_W-1:0] dec_fpu_ctrl_s;
   logic [1:0]            dec_flag_w_s;
   logic                  alu_legal_s, fpu_legal_s, is_mul_s, is_long_mul_s;
   logic                  last_exec_s;

   logic irwrite_s, nextpc_s, branch_s, regw_s, memw_s, mul_hi_s, fpu_start_s;

   multicycle_decode_fn #(
      .ALU_CTRL_W (ALU_CTRL_W),
      .FPU_CTRL_W (FPU_CTRL_W)
   ) u_fn (
      .funct_i       (Funct),
      .mul_op_i      (MulOp),
      .alu_ctrl_o    (dec_alu_ctrl_s),
      .fpu_ctrl_o    (dec_fpu_ctrl_s),
      .flag_w_o      (dec_flag_w_s),
      .alu_legal_o   (alu_legal_s),
      .fpu_legal_o   (fpu_legal_s),
      .is_mul_o      (is_mul_s),
      .is_long_mul_o (is_long_mul_s)
   );

   // State, multiply countdown and first-FPUEX-cycle marker
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= FETCH;
         cnt_q       <= CNT_RELOAD;
         fpu_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fpu_first_q <= fpu_first_d;
      end
   end

   // Next-state sequencing
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fpu_first_d = 1'b0;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            case (Op)
               OP_MEM: state_d = MEMADR;
               OP_BR:  state_d = BRANCH;
               OP_FPU: begin
                  state_d     = FPUEX;
                  fpu_first_d = 1'b1;
               end
               default: begin
                  if (is_mul_s) begin
                     state_d = MULEX;
                     cnt_d   = CNT_RELOAD;
                  end else if (Funct[5]) begin
                     state_d = EXECI;
                  end else begin
                     state_d = EXECR;
                  end
               end
            endcase
         end
         MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
         MEMRD:  state_d = MEMWB;
         MEMWB:  state_d = FETCH;
         MEMWR:  state_d = FETCH;
         EXECR,
         EXECI:  state_d = alu_legal_s ? ALUWB : FETCH;
         MULEX: begin
            if (!alu_legal_s) begin
               state_d = FETCH;
            end else if (cnt_q == '0) begin
               state_d = ALUWB;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ALUWB:    state_d = ((Op == OP_DP) && is_long_mul_s) ? MULWB_HI : FETCH;
         MULWB_HI: state_d = FETCH;
         BRANCH:   state_d = FETCH;
         FPUEX: begin
            // The FPU cannot answer in the start cycle, so done is only looked at afterwards
            if (!fpu_legal_s) begin
               state_d = FETCH;
            end else if (fpu_first_q) begin
               state_d = FPUEX;
            end else if (fpu_done) begin
               state_d = FPUWB;
            end else begin
               state_d = FPUEX;
            end
         end
         FPUWB:   state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   assign last_exec_s = (state_q == EXECR) || (state_q == EXECI) ||
                        ((state_q == MULEX) && (cnt_q == '0));

   // Moore outputs per state
   always_comb begin
      irwrite_s   = 1'b0;
      nextpc_s    = 1'b0;
      branch_s    = 1'b0;
      regw_s      = 1'b0;
      memw_s      = 1'b0;
      mul_hi_s    = 1'b0;
      fpu_start_s = 1'b0;
      AdrSrc      = 1'b0;
      ALUSrcA     = 1'b0;
      ResultSrc   = 2'b00;
      ALUSrcB     = 2'b00;
      ALUControl  = ALU_CTRL_W'(ALU_ADD);
      FPUControl  = {FPU_CTRL_W{1'b0}};
      FlagW       = 2'b00;
      FPUFlagW    = 2'b00;
      case (state_q)
         FETCH: begin
            irwrite_s = 1'b1;
            nextpc_s  = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         MEMADR: ALUSrcB = 2'b01;
         MEMRD:  AdrSrc  = 1'b1;
         MEMWR: begin
            AdrSrc = 1'b1;
            memw_s = 1'b1;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            regw_s    = 1'b1;
            nextpc_s  = (Rd == 4'b1111);
         end
         EXECR, MULEX: begin
            ALUSrcB    = 2'b00;
            ALUControl = dec_alu_ctrl_s;
            FlagW      = last_exec_s ? dec_flag_w_s : 2'b00;
         end
         EXECI: begin
            ALUSrcB    = 2'b01;
            ALUControl = dec_alu_ctrl_s;
            FlagW      = last_exec_s ? dec_flag_w_s : 2'b00;
         end
         ALUWB: begin
            regw_s   = 1'b1;
            nextpc_s = (Rd == 4'b1111);
         end
         MULWB_HI: begin
            regw_s   = 1'b1;
            mul_hi_s = 1'b1;
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            branch_s  = 1'b1;
         end
         FPUEX: begin
            fpu_start_s = fpu_first_q & fpu_legal_s;
            FPUControl  = dec_fpu_ctrl_s;
         end
         FPUWB: begin
            ResultSrc  = 2'b11;
            regw_s     = 1'b1;
            nextpc_s   = (Rd == 4'b1111);
            FPUControl = dec_fpu_ctrl_s;
            FPUFlagW   = {Funct[0], 1'b0};
         end
         default: begin
            irwrite_s = 1'b0;
         end
      endcase
   end

   assign ImmSrc = Op;
   assign RegSrc = {Op == OP_MEM, Op == OP_BR};

   // Strobes drop the instant reset is asserted, even mid-instruction
   assign IRWrite   = irwrite_s   & reset;
   assign NextPC    = nextpc_s    & reset;
   assign Branch    = branch_s    & reset;
   assign RegW      = regw_s      & reset;
   assign MemW      = memw_s      & reset;
   assign mul_hi    = mul_hi_s    & reset;
   assign fpu_start = fpu_start_s & reset;

endmodule

// File: tb/tb_multicycle_decode.sv
// Self-checking bench for multicycle_decode: each instruction is expanded by
// a reference model into its expected per-cycle output records.
module tb_multicycle_decode;

   localparam int MC = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] Op = 2'b00;
   logic [5:0] Funct = 6'd0;
   logic [3:0] Rd = 4'd0;
   logic [3:0] MulOp = 4'd0;
   logic       fpu_done = 1'b0;
   logic IRWrite, NextPC, Branch, RegW, MemW, AdrSrc, ALUSrcA, mul_hi, fpu_start;
   logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, FlagW, FPUFlagW, FPUControl;
   logic [2:0] ALUControl;

   typedef struct packed {
      logic       irw, npc, br, regw, memw, adr, asa, mhi, fst;
      logic [1:0] rsrc, bsrc, imm, rsel;
      logic [2:0] alu;
      logic [1:0] fpuc, flg, fflg;
   } out_t;

   out_t obs_s;
   out_t exp_q[$];
   logic done_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   multicycle_decode #(.ALU_CTRL_W(3), .FPU_CTRL_W(2), .MUL_CYCLES(MC)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MulOp(MulOp),
      .fpu_done(fpu_done), .IRWrite(IRWrite), .NextPC(NextPC), .Branch(Branch),
      .RegW(RegW), .MemW(MemW), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .mul_hi(mul_hi),
      .fpu_start(fpu_start), .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .RegSrc(RegSrc), .ALUControl(ALUControl), .FPUControl(FPUControl),
      .FlagW(FlagW), .FPUFlagW(FPUFlagW)
   );

   always #5 clk = ~clk;

   assign obs_s = {IRWrite, NextPC, Branch, RegW, MemW, AdrSrc, ALUSrcA, mul_hi, fpu_start,
                   ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, FPUControl, FlagW, FPUFlagW};

   task automatic check(input string tag, input out_t o, input out_t e);
      n_cmp++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   function automatic out_t base(input logic [1:0] op);
      out_t c;
      c      = '0;
      c.imm  = op;
      c.rsel = {op == 2'b01, op == 2'b10};
      c.alu  = 3'd0;
      return c;
   endfunction

   function automatic out_t fetch_vals(input logic [1:0] op);
      out_t c;
      c      = base(op);
      c.asa  = 1'b1;
      c.bsrc = 2'b10;
      c.rsrc = 2'b10;
      return c;
   endfunction

   task automatic push(input out_t c, input logic d);
      exp_q.push_back(c);
      done_q.push_back(d);
   endtask

   // Expand one instruction into expected cycles; done_pat[i] drives fpu_done in FPUEX cycle i
   task automatic build(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                        input logic [3:0] mulop, input logic [7:0] done_pat);
      out_t       c;
      logic [2:0] alu;
      bit         mul;
      int         n;
      exp_q.delete();
      done_q.delete();
      c = fetch_vals(op); c.irw = 1'b1; c.npc = 1'b1; push(c, 1'($urandom));
      c = fetch_vals(op); push(c, 1'($urandom));
      if (op == 2'b01) begin
         c = base(op); c.bsrc = 2'b01; push(c, 1'($urandom));
         if (funct[0]) begin
            c = base(op); c.adr = 1'b1; push(c, 1'($urandom));
            c = base(op); c.rsrc = 2'b01; c.regw = 1'b1; c.npc = (rd == 4'hF); push(c, 1'($urandom));
         end else begin
            c = base(op); c.adr = 1'b1; c.memw = 1'b1; push(c, 1'($urandom));
         end
      end else if (op == 2'b10) begin
         c = base(op); c.bsrc = 2'b01; c.rsrc = 2'b10; c.br = 1'b1; push(c, 1'($urandom));
      end else if (op == 2'b11) begin
         c = base(op); c.fpuc = funct[2:1]; c.fst = 1'b1; push(c, done_pat[0]);
         for (int i = 1; i < 8; i++) begin
            c = base(op); c.fpuc = funct[2:1]; push(c, done_pat[i]);
            if (done_pat[i]) break;
         end
         c = base(op); c.rsrc = 2'b11; c.regw = 1'b1; c.npc = (rd == 4'hF);
         c.fpuc = funct[2:1]; c.fflg = {funct[0], 1'b0}; push(c, 1'($urandom));
      end else begin
         mul = (mulop == 4'b1001) && !funct[5];
         if (mul) begin
            case (funct[3:1])
               3'b000:  alu = 3'd4;
               3'b100:  alu = 3'd5;
               3'b110:  alu = 3'd6;
               default: alu = 3'd7;
            endcase
         end else begin
            case (funct[4:1])
               4'b0100: alu = 3'd0;
               4'b0010: alu = 3'd1;
               4'b0000: alu = 3'd2;
               4'b1100: alu = 3'd3;
               default: alu = 3'd7;
            endcase
         end
         n = (mul && alu != 3'd7) ? MC : 1;
         for (int i = 0; i < n; i++) begin
            c = base(op); c.alu = alu; c.bsrc = funct[5] ? 2'b01 : 2'b00;
            if (i == n - 1 && alu != 3'd7) c.flg = {funct[0], funct[0] & (alu <= 3'd1)};
            push(c, 1'($urandom));
         end
         if (alu != 3'd7) begin
            c = base(op); c.regw = 1'b1; c.npc = (rd == 4'hF); push(c, 1'($urandom));
            if (alu == 3'd5 || alu == 3'd6) begin
               c = base(op); c.regw = 1'b1; c.mhi = 1'b1; push(c, 1'($urandom));
            end
         end
      end
   endtask

   // Run the expected cycles; entered and left just after a rising edge
   task automatic run(input string tag, input logic [1:0] op, input logic [5:0] funct,
                      input logic [3:0] rd, input logic [3:0] mulop, input logic [7:0] done_pat,
                      input int limit);
      int len;
      build(op, funct, rd, mulop, done_pat);
      Op = op; Funct = funct; Rd = rd; MulOp = mulop;
      len = (limit < 0 || limit > exp_q.size()) ? exp_q.size() : limit;
      for (int i = 0; i < len; i++) begin
         fpu_done = done_q[i];
         @(negedge clk);
         check($sformatf("%s.c%0d", tag, i), obs_s, exp_q[i]);
         @(posedge clk);
         #1;
      end
      fpu_done = 1'b0;
   endtask

   logic [3:0] dp_tab [4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
   logic [2:0] mul_tab [3] = '{3'b000, 3'b100, 3'b110};

   initial begin
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] rd, mulop;
      logic [7:0] pat;
      out_t       e;

      // Reset held: FETCH values with strobes forced low
      Op = 2'b01; Funct = 6'b011001;
      for (int i = 0; i < 3; i++) begin
         fpu_done = 1'($urandom);
         @(negedge clk);
         check($sformatf("reset_hold%0d", i), obs_s, fetch_vals(2'b01));
      end
      @(posedge clk); #1;
      reset = 1'b1;

      // Directed cases from the plan
      run("add",   2'b00, 6'b001000, 4'd1,  4'b0000, 8'h00, -1);
      run("subs",  2'b00, 6'b100101, 4'd2,  4'b0000, 8'h00, -1);
      run("smull", 2'b00, 6'b001100, 4'd3,  4'b1001, 8'h00, -1);
      run("umull", 2'b00, 6'b001001, 4'd4,  4'b1001, 8'h00, -1);
      run("mul",   2'b00, 6'b000001, 4'hF,  4'b1001, 8'h00, -1);
      run("fpu",   2'b11, 6'b000011, 4'd5,  4'b0000, 8'b0001_0001, -1);
      run("ldrpc", 2'b01, 6'b011001, 4'hF,  4'b0000, 8'h00, -1);
      run("str",   2'b01, 6'b011000, 4'd6,  4'b0000, 8'h00, -1);
      run("b",     2'b10, 6'b000000, 4'd0,  4'b0000, 8'h00, -1);
      run("illdp", 2'b00, 6'b011110, 4'd7,  4'b0000, 8'h00, -1);
      run("illmul",2'b00, 6'b000010, 4'd7,  4'b1001, 8'h00, -1);
      run("addpc", 2'b00, 6'b101001, 4'hF,  4'b0000, 8'h00, -1);

      // Reset during the second MULEX cycle aborts at once
      run("mulabort", 2'b00, 6'b001100, 4'd3, 4'b1001, 8'h00, 3);
      reset = 1'b0;
      #1;
      check("abort_now", obs_s, fetch_vals(2'b00));
      @(negedge clk);
      check("abort_hold", obs_s, fetch_vals(2'b00));
      @(posedge clk); #1;
      reset = 1'b1;
      run("mulfresh", 2'b00, 6'b001100, 4'd3, 4'b1001, 8'h00, -1);

      // Randomized instruction stream
      for (int k = 0; k < 40; k++) begin
         op = 2'($urandom_range(0, 3));
         funct = 6'($urandom);
         rd = 4'($urandom);
         mulop = 4'($urandom);
         if (op == 2'b00) begin
            if ($urandom_range(0, 2) == 0) begin
               funct[5] = 1'b0;
               mulop = 4'b1001;
               if ($urandom_range(0, 3) != 0) funct[3:1] = mul_tab[$urandom_range(0, 2)];
            end else begin
               if (funct[5] && mulop == 4'b1001) mulop = 4'b0000;
               if ($urandom_range(0, 3) != 0) funct[4:1] = dp_tab[$urandom_range(0, 3)];
            end
         end
         if (op == 2'b11) funct[4:3] = 2'b00;
         pat = 8'($urandom) & 8'h0F;
         pat[$urandom_range(1, 4)] = 1'b1;
         run($sformatf("rnd%0d", k), op, funct, rd, mulop, pat, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
